// File: rtl/reg_writeback_pkg.sv
// Shared register-file types plus the write-back FIFO entry and default sizing.
package reg_writeback_pkg;

  typedef logic        Bit_t;
  typedef logic [4:0]  Reg_addr_t;
  typedef logic [31:0] Reg_data_t;

  localparam Reg_addr_t REG_ZERO  = 5'd0;
  localparam Reg_data_t ZERO_WORD = 32'd0;

  typedef struct packed {
    Reg_addr_t addr;
    Reg_data_t data;
  } Wb_entry_t;

  localparam int WB_FIFO_DEPTH   = 4;
  localparam int WB_STARVE_LIMIT = 8;

  // r0 is hardwired, so it never matches anything for hazard purposes
  function automatic Bit_t addr_hit(Reg_addr_t query, Reg_addr_t addr);
    return (query == addr) && (query != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// Circular buffer holding mul/div results waiting for a free write slot.
// Every slot's address and valid bit are exported for the pending lookup.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter  int DEPTH = WB_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  Wb_entry_t        push_entry,
  input  logic             pop,
  output Wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output Reg_addr_t        entry_addr [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  Wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // storage needs no reset: validity comes from the pointers and count alone
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // a slot is live when its distance from the read pointer is below the count
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset      = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, offset} < count_q);
      entry_addr[i]  = mem[i].addr;
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/reg_writeback.sv
// Register-file write port arbiter: ALU results always win, buffered mul/div
// results fill idle slots, and a starvation counter asks for a bubble.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH        = WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      alu_valid,
  input  Reg_addr_t alu_addr,
  input  Reg_data_t alu_data,
  input  logic      md_valid,
  output logic      md_ready,
  input  Reg_addr_t md_addr,
  input  Reg_data_t md_data,
  output logic      write_enable,
  output Reg_addr_t write_addr,
  output Reg_data_t write_data,
  input  Reg_addr_t query_addr_1,
  input  Reg_addr_t query_addr_2,
  output logic      pending_1,
  output logic      pending_2,
  output logic      stall_req
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  Wb_entry_t        fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  Reg_addr_t        fifo_addr [DEPTH];
  logic [DEPTH-1:0] fifo_valid;

  logic             alu_take;
  logic             fifo_push;
  logic             fifo_pop;
  logic [STV_W-1:0] starve_cnt;
  logic [STV_W-1:0] starve_next;

  // ready depends only on registered occupancy, so a same-cycle pop never helps
  assign md_ready  = (fifo_count < CNT_W'(DEPTH));
  assign alu_take  = alu_valid && (alu_addr != REG_ZERO);
  // r0 results complete the handshake but are simply dropped
  assign fifo_push = md_valid && !fifo_full && (md_addr != REG_ZERO);
  assign fifo_pop  = !alu_take && !fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .push_entry  ('{addr: md_addr, data: md_data}),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_addr  (fifo_addr),
    .entry_valid (fifo_valid)
  );

  // registered write port: ALU first, then FIFO head, otherwise hold addr/data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_enable <= 1'b0;
      write_addr   <= REG_ZERO;
      write_data   <= ZERO_WORD;
    end else if (alu_take) begin
      write_enable <= 1'b1;
      write_addr   <= alu_addr;
      write_data   <= alu_data;
    end else if (fifo_pop) begin
      write_enable <= 1'b1;
      write_addr   <= fifo_head.addr;
      write_data   <= fifo_head.data;
    end else begin
      write_enable <= 1'b0;
    end
  end

  // count cycles the head is blocked by ALU writes, saturating at the limit
  always_comb begin
    starve_next = starve_cnt;
    if (fifo_empty || fifo_pop) begin
      starve_next = '0;
    end else if (alu_take && (starve_cnt != STV_W'(STARVE_LIMIT))) begin
      starve_next = starve_cnt + STV_W'(1);
    end
  end

  // stall_req mirrors the saturated state of the registered counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      stall_req  <= (starve_next == STV_W'(STARVE_LIMIT));
    end
  end

  // a source is pending while its result is buffered or being written now
  always_comb begin
    pending_1 = write_enable && addr_hit(query_addr_1, write_addr);
    pending_2 = write_enable && addr_hit(query_addr_2, write_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i] && addr_hit(query_addr_1, fifo_addr[i])) pending_1 = 1'b1;
      if (fifo_valid[i] && addr_hit(query_addr_2, fifo_addr[i])) pending_2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      alu_valid = 1'b0;
  Reg_addr_t alu_addr = '0;
  Reg_data_t alu_data = '0;
  logic      md_valid = 1'b0;
  logic      md_ready;
  Reg_addr_t md_addr = '0;
  Reg_data_t md_data = '0;
  logic      write_enable;
  Reg_addr_t write_addr;
  Reg_data_t write_data;
  Reg_addr_t query_addr_1 = '0;
  Reg_addr_t query_addr_2 = '0;
  logic      pending_1;
  logic      pending_2;
  logic      stall_req;

  reg_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .md_valid     (md_valid),
    .md_ready     (md_ready),
    .md_addr      (md_addr),
    .md_data      (md_data),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .query_addr_1 (query_addr_1),
    .query_addr_2 (query_addr_2),
    .pending_1    (pending_1),
    .pending_2    (pending_2),
    .stall_req    (stall_req)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model: port state, a queue of buffered results, a starve tally
  Wb_entry_t mq[$];
  logic      m_we;
  Reg_addr_t m_wa;
  Reg_data_t m_wd;
  int        m_starve;
  logic      m_stall;

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
    m_starve = 0;
    m_stall = 1'b0;
  endtask

  function automatic logic m_pending(Reg_addr_t a);
    if (a == REG_ZERO) return 1'b0;
    if (m_we && m_wa == a) return 1'b1;
    foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic av, input int aa, input int ad,
                       input logic mv, input int ma, input int mdd,
                       input int q1 = 0, input int q2 = 0);
    alu_valid    = av;
    alu_addr     = Reg_addr_t'(aa);
    alu_data     = Reg_data_t'(ad);
    md_valid     = mv;
    md_addr      = Reg_addr_t'(ma);
    md_data      = Reg_data_t'(mdd);
    query_addr_1 = Reg_addr_t'(q1);
    query_addr_2 = Reg_addr_t'(q2);
  endtask

  // one clock: check combinational outputs, advance model and DUT, check registers
  task automatic cycle();
    logic accept, alu_w, popped, was_empty;
    #1;
    check("md_ready", md_ready, (mq.size() < DEPTH));
    check("pending_1", pending_1, m_pending(query_addr_1));
    check("pending_2", pending_2, m_pending(query_addr_2));
    accept    = md_valid && (mq.size() < DEPTH);
    alu_w     = alu_valid && (alu_addr != REG_ZERO);
    was_empty = (mq.size() == 0);
    popped    = 1'b0;
    if (alu_w) begin
      m_we = 1'b1; m_wa = alu_addr; m_wd = alu_data;
    end else if (!was_empty) begin
      m_we = 1'b1; m_wa = mq[0].addr; m_wd = mq[0].data;
      void'(mq.pop_front());
      popped = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (was_empty || popped) m_starve = 0;
    else if (alu_w && m_starve < LIMIT) m_starve++;
    m_stall = (m_starve == LIMIT);
    if (accept && md_addr != REG_ZERO) mq.push_back('{addr: md_addr, data: md_data});
    @(posedge clk);
    #1;
    check("write_enable", write_enable, m_we);
    check("write_addr", write_addr, m_wa);
    check("write_data", write_data, m_wd);
    check("stall_req", stall_req, m_stall);
  endtask

  initial begin
    int rise;
    int prob;
    model_reset();
    #2;
    check("rst_we", write_enable, 1'b0);
    check("rst_wa", write_addr, REG_ZERO);
    check("rst_wd", write_data, ZERO_WORD);
    check("rst_stall", stall_req, 1'b0);
    #10 rst = 1'b1;

    // single ALU write, then idle
    drive(1, 5, 'h1234, 0, 0, 0);
    cycle();
    check("t1_addr", write_addr, 5'd5);
    check("t1_data", write_data, 32'h1234);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    check("t1_idle_we", write_enable, 1'b0);

    // ALU and mul/div in the same cycle
    drive(1, 3, 'hA, 1, 7, 'hB, 7, 3);
    cycle();
    check("t2_alu_first", write_addr, 5'd3);
    check("t2_pend7_buf", pending_1, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 7, 3);
    cycle();
    check("t2_md_second", write_addr, 5'd7);
    check("t2_md_data", write_data, 32'hB);
    cycle();
    check("t2_pend7_clear", pending_1, 1'b0);

    // fill the FIFO while ALU holds the port
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 20, 'h200 + i, 1, 8 + i, 'h80 + i, 8 + i, 20);
      cycle();
    end
    drive(1, 20, 'h2FF, 1, 12, 'hCC, 12, 11);
    check("t3_full_ready", md_ready, 1'b0);
    cycle();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 0, 0, 0, 12, 8 + i);
      cycle();
      check("t3_drain_addr", write_addr, Reg_addr_t'(8 + i));
    end
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    check("t3_no_fifth", write_enable, 1'b0);

    // starvation: stall_req after LIMIT blocked cycles, one bubble clears it
    drive(1, 22, 'h22, 1, 6, 'h66, 6, 22);
    cycle();
    rise = -1;
    for (int i = 1; i <= 20; i++) begin
      drive(1, 22, 'h100 + i, 0, 0, 0, 6, 22);
      cycle();
      if (stall_req) begin
        rise = i;
        break;
      end
    end
    check("t4_stall_rise", rise, LIMIT);
    drive(1, 23, 'h23, 0, 0, 0, 6, 23);
    cycle();
    check("t4_alu_in_stall", write_addr, 5'd23);
    drive(0, 0, 0, 0, 0, 0, 6, 0);
    cycle();
    check("t4_head_written", write_addr, 5'd6);
    check("t4_stall_fall", stall_req, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    cycle();

    // writes aimed at r0
    drive(1, 9, 'h99, 1, 4, 'h55, 4, 0);
    cycle();
    drive(1, 0, 'hDEAD, 1, 0, 'hBEEF, 4, 0);
    check("t5_r0_ready", md_ready, 1'b1);
    cycle();
    check("t5_reg4", write_addr, 5'd4);
    check("t5_reg4_data", write_data, 32'h55);
    drive(0, 0, 0, 0, 0, 0, 4, 0);
    cycle();
    check("t5_no_r0_write", write_enable, 1'b0);

    // asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      drive(1, 25, 'h25, 1, 12 + i, 'hC0 + i, 13, 14);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 13, 14);
    cycle();
    rst = 1'b0;
    #1;
    check("t6_rst_we", write_enable, 1'b0);
    check("t6_rst_wa", write_addr, REG_ZERO);
    check("t6_rst_wd", write_data, ZERO_WORD);
    check("t6_rst_pend", pending_1, 1'b0);
    model_reset();
    #3 rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // randomized traffic in phases of differing ALU pressure
    for (int seg = 0; seg < 4; seg++) begin
      case (seg)
        0:       prob = 90;
        1:       prob = 30;
        2:       prob = 60;
        default: prob = 97;
      endcase
      for (int n = 0; n < 150; n++) begin
        alu_valid = ($urandom_range(99) < prob) && !m_stall;
        alu_addr  = Reg_addr_t'($urandom_range(31));
        alu_data  = $urandom();
        if (m_pending(alu_addr)) alu_valid = 1'b0;
        md_valid  = ($urandom_range(99) < 50);
        md_addr   = Reg_addr_t'($urandom_range(31));
        md_data   = $urandom();
        if (mq.size() > 0 && $urandom_range(1) == 1)
          query_addr_1 = mq[$urandom_range(mq.size() - 1)].addr;
        else
          query_addr_1 = Reg_addr_t'($urandom_range(31));
        query_addr_2 = Reg_addr_t'($urandom_range(31));
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
